// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared widths, depth derivation and default thresholds for
//                the single-clock FIFO controller and its pointer counters.
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_pkg;

    // Default SRAM address width; the pointers carry one extra wrap bit.
    localparam int unsigned c_ADDR_W    = 5;
    localparam int unsigned c_PTR_W     = c_ADDR_W + 1;
    localparam int unsigned c_CNT_W     = c_ADDR_W + 1;

    // Default occupancy thresholds for the almost flags.
    localparam int unsigned c_AF_THRESH = 28;
    localparam int unsigned c_AE_THRESH = 4;

    // Number of entries addressed by an address of the given width.
    function automatic int unsigned f_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    localparam int unsigned c_DEPTH     = f_depth(c_ADDR_W);

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/ptr_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : ptr_ctr
//  Description : Wrap-around pointer counter with increment enable and a
//                synchronous load. Load has priority over increment.
//  Revision    : 1.0  initial release
// ============================================================================
module ptr_ctr #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_q;

    // Pointer register: natural binary wrap modulo 2**WIDTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= load_val;
        end else if (inc) begin
            r_q <= r_q + c_ONE;
        end
    end

    assign q = r_q;

endmodule : ptr_ctr
`default_nettype wire

// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_ctrl
//  Description : Single-clock FIFO controller sequencing a dual-port SRAM as a
//                circular buffer. Owns the read/write pointers, occupancy
//                count, status flags and sticky error flags. Data bypasses
//                this block entirely.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W    = c_ADDR_W,
    parameter int AF_THRESH = c_AF_THRESH,
    parameter int AE_THRESH = c_AE_THRESH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic              clr_err,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              rd_valid,
    output logic              overflow,
    output logic              underflow,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr
);

    localparam int unsigned     DEPTH      = f_depth(ADDR_W);
    localparam logic [ADDR_W:0] c_CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_CNT_AF   = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] c_CNT_AE   = (ADDR_W+1)'(AE_THRESH);
    localparam logic [ADDR_W:0] c_CNT_ONE  = (ADDR_W+1)'(1);

    logic [ADDR_W:0] w_wptr;
    logic [ADDR_W:0] w_rptr;
    logic [ADDR_W:0] r_count;
    logic            r_rd_valid;
    logic            r_overflow;
    logic            r_underflow;
    logic            w_full;
    logic            w_empty;
    logic            w_wr_acc;
    logic            w_rd_acc;

    // Flags come from the registered count only, never from this cycle's requests.
    assign w_full  = (r_count == c_CNT_FULL);
    assign w_empty = (r_count == '0);

    // A flush swallows both requests; otherwise accept against start-of-cycle flags.
    assign w_wr_acc = push && !w_full  && !flush;
    assign w_rd_acc = pop  && !w_empty && !flush;

    // Write pointer never loads: a flush moves the read side up to it instead.
    ptr_ctr #(
        .WIDTH    (ADDR_W + 1)
    ) u_wptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (1'b0),
        .load_val ('0),
        .inc      (w_wr_acc),
        .q        (w_wptr)
    );

    // Read pointer snaps to the write pointer on flush, emptying the buffer.
    ptr_ctr #(
        .WIDTH    (ADDR_W + 1)
    ) u_rptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (flush),
        .load_val (w_wptr),
        .inc      (w_rd_acc),
        .q        (w_rptr)
    );

    // Occupancy tracks accepted writes minus accepted reads.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_count <= '0;
        end else if (w_wr_acc && !w_rd_acc) begin
            r_count <= r_count + c_CNT_ONE;
        end else if (!w_wr_acc && w_rd_acc) begin
            r_count <= r_count - c_CNT_ONE;
        end
    end

    // Read data strobe lines up with the SRAM's registered output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
        end
    end

    // Sticky error flags; a new error in the clearing cycle takes precedence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (push && w_full && !flush) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (pop && w_empty && !flush) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_CNT_AF);
    assign almost_empty = (r_count <= c_CNT_AE);
    assign count        = r_count;
    assign rd_valid     = r_rd_valid;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    assign ram_wr_en    = w_wr_acc;
    assign ram_wr_addr  = w_wptr[ADDR_W-1:0];
    assign ram_rd_en    = w_rd_acc;
    assign ram_rd_addr  = w_rptr[ADDR_W-1:0];

endmodule : sync_fifo_ctrl
`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_ctrl
//  Description : Self-checking bench for sync_fifo_ctrl with a behavioural
//                SRAM and a queue-based reference model of the FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sync_fifo_ctrl;

    localparam int c_DEPTH = 32;
    localparam int c_AF    = 28;
    localparam int c_AE    = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       flush = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] d_in = 8'h00;
    logic       full, empty, almost_full, almost_empty;
    logic [5:0] count;
    logic       rd_valid, overflow, underflow;
    logic       ram_wr_en, ram_rd_en;
    logic [4:0] ram_wr_addr, ram_rd_addr;

    // Behavioural 32x8 SRAM, both ports on clk, registered read data.
    logic [7:0] mem [0:31];
    logic [7:0] d_out;

    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= d_in;
        if (ram_rd_en) d_out <= mem[ram_rd_addr];
    end

    always #5 clk = ~clk;

    sync_fifo_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push),
        .pop          (pop),
        .flush        (flush),
        .clr_err      (clr_err),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .rd_valid     (rd_valid),
        .overflow     (overflow),
        .underflow    (underflow),
        .ram_wr_en    (ram_wr_en),
        .ram_wr_addr  (ram_wr_addr),
        .ram_rd_en    (ram_rd_en),
        .ram_rd_addr  (ram_rd_addr)
    );

    // Reference model state
    logic [7:0] q [$];
    int         wr_total = 0;
    int         rd_total = 0;
    logic       m_rdv = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_known = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check SRAM drive, clock, check registered state.
    task automatic step(input logic rst_v, input logic push_v, input logic pop_v,
                        input logic flush_v, input logic clr_v, input logic [7:0] data_v);
        logic m_full, m_empty, e_wr, e_rd;
        @(negedge clk);
        rst_n   = rst_v;
        push    = push_v;
        pop     = pop_v;
        flush   = flush_v;
        clr_err = clr_v;
        d_in    = data_v;
        #1;
        m_full  = (q.size() == c_DEPTH);
        m_empty = (q.size() == 0);
        e_wr    = push_v && !m_full && !flush_v;
        e_rd    = pop_v && !m_empty && !flush_v;
        if (m_known) begin
            chk("ram_wr_en",   32'(ram_wr_en),   32'(e_wr));
            chk("ram_wr_addr", 32'(ram_wr_addr), 32'(wr_total % c_DEPTH));
            chk("ram_rd_en",   32'(ram_rd_en),   32'(e_rd));
            chk("ram_rd_addr", 32'(ram_rd_addr), 32'(rd_total % c_DEPTH));
        end
        @(posedge clk);
        #1;
        if (!rst_v) begin
            q.delete();
            wr_total = 0;
            rd_total = 0;
            m_rdv    = 1'b0;
            m_ovf    = 1'b0;
            m_udf    = 1'b0;
            m_known  = 1'b1;
        end else begin
            m_ovf = (push_v && m_full && !flush_v) ? 1'b1 : (clr_v ? 1'b0 : m_ovf);
            m_udf = (pop_v && m_empty && !flush_v) ? 1'b1 : (clr_v ? 1'b0 : m_udf);
            if (flush_v) begin
                q.delete();
                rd_total = wr_total;
                m_rdv    = 1'b0;
            end else begin
                if (e_rd) begin
                    m_data = q.pop_front();
                    rd_total++;
                end
                if (e_wr) begin
                    q.push_back(data_v);
                    wr_total++;
                end
                m_rdv = e_rd;
            end
        end
        if (m_known) begin
            chk("count",        32'(count),        32'(q.size()));
            chk("full",         32'(full),         32'(q.size() == c_DEPTH));
            chk("empty",        32'(empty),        32'(q.size() == 0));
            chk("almost_full",  32'(almost_full),  32'(q.size() >= c_AF));
            chk("almost_empty", 32'(almost_empty), 32'(q.size() <= c_AE));
            chk("rd_valid",     32'(rd_valid),     32'(m_rdv));
            chk("overflow",     32'(overflow),     32'(m_ovf));
            chk("underflow",    32'(underflow),    32'(m_udf));
            if (m_rdv) chk("d_out", 32'(d_out), 32'(m_data));
        end
    endtask

    initial begin
        // 1. Reset for two cycles, then release
        step(0, 0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00);

        // 2. Fill with 0x00..0x1F, then one push too many
        for (int i = 0; i < 32; i++) step(1, 1, 0, 0, 0, 8'(i));
        step(1, 1, 0, 0, 0, 8'hAA);

        // 3. Drain, pop once more while empty, then clear errors
        for (int i = 0; i < 32; i++) step(1, 0, 1, 0, 0, 8'h00);
        step(1, 0, 1, 0, 0, 8'h00);
        step(1, 0, 0, 0, 1, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00);

        // 4. Address wrap from a fresh reset
        step(0, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 8'(8'h40 + i));
        for (int i = 0; i < 20; i++) step(1, 0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 8'(8'h80 + i));
        for (int i = 0; i < 20; i++) step(1, 0, 1, 0, 0, 8'h00);

        // 5. Simultaneous push and pop at count 5, full and empty
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 8'(8'h10 + i));
        step(1, 1, 1, 0, 0, 8'h55);
        for (int i = 0; i < 27; i++) step(1, 1, 0, 0, 0, 8'(8'hC0 + i));
        step(1, 1, 1, 0, 0, 8'h66);
        step(1, 0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 31; i++) step(1, 0, 1, 0, 0, 8'h00);
        step(1, 1, 1, 0, 0, 8'h77);
        step(1, 0, 0, 0, 0, 8'h00);
        step(1, 0, 1, 0, 1, 8'h00);

        // 6. Flush at count 10 with pop, then reset in the middle of a pop burst
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0, 8'(8'h20 + i));
        step(1, 0, 1, 1, 0, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0, 8'(8'h30 + i));
        step(1, 0, 1, 0, 0, 8'h00);
        step(1, 0, 1, 0, 0, 8'h00);
        step(0, 0, 1, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00);

        // Randomised traffic, alternating fill-biased and drain-biased phases
        for (int n = 0; n < 600; n++) begin
            logic pu, po, fl, cl, rs;
            int   bias;
            bias = ((n / 60) % 2 == 0) ? 75 : 25;
            pu = ($urandom_range(0, 99) < bias);
            po = ($urandom_range(0, 99) < (100 - bias));
            fl = ($urandom_range(0, 59) == 0);
            cl = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 249) != 0);
            step(rs, pu, po, fl, cl, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_sync_fifo_ctrl
`default_nettype wire
